inst_mem_loader: RTL and testbench

INST_MEM_LOADER -- requirements
Module: inst_mem_loader

---
 rtl/inst_mem_loader.sv | 128 ++++++++++++
 tb/tb_inst_mem_loader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// Instruction memory loader: a word stream fills the memory during LOAD,
// then word-aligned fetches are served with one cycle of latency in RUN.
// A fetched HALT_WORD ends in HALT; a misaligned or out-of-program fetch
// ends in FAULT. Only reset leaves either of these states.
module inst_mem_loader #(
    parameter int                DEPTH     = 32,
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(32'hB4221820)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ld_valid,
    input  logic [DATA_W-1:0]          ld_data,
    input  logic                       ld_last,
    output logic                       ld_ready,
    input  logic                       fetch_req,
    input  logic [31:0]                fetch_addr,
    output logic [DATA_W-1:0]          inst_out,
    output logic                       inst_valid,
    output logic [$clog2(DEPTH+1)-1:0] prog_len,
    output logic                       halted,
    output logic                       fault
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LEN_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;

    logic              ld_accept;
    logic              fetch_fire;
    logic              fetch_bad;
    logic [31:0]       word_idx;
    logic [PTR_W-1:0]  fetch_idx;
    logic [DATA_W-1:0] rd_word;

    // Fetch address decode: a fetch is bad if misaligned or beyond the loaded program.
    always_comb begin
        word_idx  = {2'b00, fetch_addr[31:2]};
        fetch_idx = fetch_addr[PTR_W+1:2];
        fetch_bad = (fetch_addr[1:0] != 2'b00) || (word_idx >= 32'(prog_len));
        rd_word   = mem[fetch_idx];
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake qualifiers.
    always_comb begin
        state_next = state;
        ld_ready   = (state == LOAD);
        ld_accept  = ld_valid && (state == LOAD);
        fetch_fire = fetch_req && (state == RUN);
        unique case (state)
            LOAD: begin
                if (ld_accept && (ld_last || (wr_ptr == LAST_PTR))) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (fetch_req) begin
                    if (fetch_bad) begin
                        state_next = FAULT;
                    end else if (rd_word == HALT_WORD) begin
                        state_next = HALT;
                    end
                end
            end
            default: begin
                state_next = state;
            end
        endcase
    end

    // Program storage: written only on accepted load words, never cleared.
    always_ff @(posedge clk) begin
        if (ld_accept) begin
            mem[wr_ptr] <= ld_data;
        end
    end

    // Load pointer/length, fetch result register and sticky flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            prog_len   <= '0;
            inst_out   <= '0;
            inst_valid <= 1'b0;
            halted     <= 1'b0;
            fault      <= 1'b0;
        end else begin
            inst_valid <= 1'b0;
            if (ld_accept) begin
                wr_ptr   <= wr_ptr + PTR_W'(1);
                prog_len <= prog_len + LEN_W'(1);
            end
            if (fetch_fire) begin
                if (fetch_bad) begin
                    fault <= 1'b1;
                end else begin
                    inst_out   <= rd_word;
                    inst_valid <= 1'b1;
                    if (rd_word == HALT_WORD) begin
                        halted <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: stimulus pushes expected fetch
// results, a negedge monitor pops and compares on every inst_valid pulse.
module tb_inst_mem_loader;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 32;
    localparam logic [31:0] HALT = 32'hB4221820;

    logic                       clk = 1'b0;
    logic                       reset = 1'b0;
    logic                       ld_valid = 1'b0;
    logic [DATA_W-1:0]          ld_data = '0;
    logic                       ld_last = 1'b0;
    logic                       ld_ready;
    logic                       fetch_req = 1'b0;
    logic [31:0]                fetch_addr = '0;
    logic [DATA_W-1:0]          inst_out;
    logic                       inst_valid;
    logic [$clog2(DEPTH+1)-1:0] prog_len;
    logic                       halted;
    logic                       fault;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    inst_mem_loader #(
        .DEPTH    (DEPTH),
        .DATA_W   (DATA_W),
        .HALT_WORD(HALT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .fetch_req (fetch_req),
        .fetch_addr(fetch_addr),
        .inst_out  (inst_out),
        .inst_valid(inst_valid),
        .prog_len  (prog_len),
        .halted    (halted),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    // Monitor: every inst_valid pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (inst_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_inst_valid: got inst_out=%08h, required no pulse", inst_out);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (inst_out !== e) begin
                    errors++;
                    $display("FAIL inst_out: got %08h, required %08h", inst_out, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_inst_valid", 32'(inst_valid), 0);
        check("rst_prog_len", 32'(prog_len), 0);
        check("rst_flags", {30'd0, halted, fault}, 0);
        check("rst_ld_ready", 32'(ld_ready), 1);
        check("rst_inst_out", inst_out, 0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    // Fetch one address; when ok, the expected word is queued for the monitor.
    task automatic fetch(input logic [31:0] addr, input logic ok, input logic [31:0] d);
        fetch_req  = 1'b1;
        fetch_addr = addr;
        if (ok) exp_q.push_back(d);
        tick();
        fetch_req = 1'b0;
    endtask

    // Bounded drain: anything still queued is a missing inst_valid pulse.
    task automatic drain(input string name);
        tick();
        tick();
        check(name, 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    initial begin
        // Basic program ending in HALT_WORD, back-to-back fetches.
        do_reset();
        load_word(32'h00004020, 1'b0);
        load_word(32'h2009000A, 1'b0);
        load_word(HALT, 1'b1);
        check("t1_prog_len", 32'(prog_len), 3);
        check("t1_ld_ready", 32'(ld_ready), 0);
        fetch(0, 1'b1, 32'h00004020);
        fetch(4, 1'b1, 32'h2009000A);
        fetch(8, 1'b1, HALT);
        check("t1_halted", 32'(halted), 1);
        check("t1_fault", 32'(fault), 0);
        drain("t1_pending");
        fetch(0, 1'b0, 0);
        drain("t1_after_halt");
        check("t1_inst_out_hold", inst_out, HALT);

        // Out-of-program fetch faults; FAULT ignores further fetches.
        do_reset();
        load_word(32'h11111111, 1'b0);
        load_word(32'h22222222, 1'b1);
        fetch(8, 1'b0, 0);
        check("t2_fault", 32'(fault), 1);
        check("t2_inst_valid", 32'(inst_valid), 0);
        check("t2_inst_out", inst_out, 0);
        check("t2_halted", 32'(halted), 0);
        fetch(0, 1'b0, 0);
        drain("t2_after_fault");

        // Misaligned fetch faults and leaves inst_out unchanged.
        do_reset();
        load_word(32'h33333333, 1'b0);
        load_word(32'h44444444, 1'b1);
        fetch(0, 1'b1, 32'h33333333);
        fetch(2, 1'b0, 0);
        check("t3_fault", 32'(fault), 1);
        check("t3_inst_valid", 32'(inst_valid), 0);
        check("t3_inst_out", inst_out, 32'h33333333);
        drain("t3_pending");

        // Fill to DEPTH without ld_last; ld_valid in RUN must not write.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            check("t4_ld_ready_fill", 32'(ld_ready), 1);
            load_word(32'h10000000 + 32'(i), 1'b0);
        end
        check("t4_ld_ready_full", 32'(ld_ready), 0);
        check("t4_prog_len", 32'(prog_len), DEPTH);
        load_word(32'hDEADBEEF, 1'b1);
        check("t4_prog_len_run", 32'(prog_len), DEPTH);
        fetch(4 * (DEPTH - 1), 1'b1, 32'h10000000 + 32'(DEPTH - 1));
        fetch(0, 1'b1, 32'h10000000);
        check("t4_fault", 32'(fault), 0);
        drain("t4_pending");

        // Fetch during LOAD is ignored; ld_valid during RUN is ignored.
        do_reset();
        fetch(0, 1'b0, 0);
        check("t5_fault_load", 32'(fault), 0);
        check("t5_ld_ready", 32'(ld_ready), 1);
        load_word(32'h55555555, 1'b1);
        load_word(32'h66666666, 1'b0);
        check("t5_prog_len", 32'(prog_len), 1);
        fetch(0, 1'b1, 32'h55555555);
        drain("t5_pending");

        // Asynchronous reset mid-load, then reload from index 0.
        do_reset();
        load_word(32'h77777777, 1'b0);
        load_word(32'h88888888, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_prog_len", 32'(prog_len), 0);
        check("t6_async_ld_ready", 32'(ld_ready), 1);
        tick();
        reset = 1'b0;
        load_word(32'hCAFE0001, 1'b1);
        check("t6_prog_len", 32'(prog_len), 1);
        check("t6_flags", {30'd0, halted, fault}, 0);
        fetch(0, 1'b1, 32'hCAFE0001);
        drain("t6_pending");

        // A fetch pending when reset hits must produce no pulse afterwards.
        fetch_req  = 1'b1;
        fetch_addr = 0;
        #2;
        reset = 1'b1;
        tick();
        fetch_req = 1'b0;
        reset = 1'b0;
        drain("t6_reset_fetch");
        check("t6_inst_valid", 32'(inst_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
